// File: rtl/food_spawn_arbiter_if.sv
// rtl/food_spawn_arbiter_if.sv - request/response bundle between collision logic and food spawn arbiter
// Optional seed-load signals present only when FOOD_SEED_LOAD_EN is defined.
interface food_spawn_arbiter_if;
    logic       food_valid_1;
    logic       food_valid_2;
    logic [7:0] new_food_x1;
    logic [6:0] new_food_y1;
    logic [7:0] new_food_x2;
    logic [6:0] new_food_y2;
    logic       food_received_1;
    logic       food_received_2;
    logic       busy;
`ifdef FOOD_SEED_LOAD_EN
    logic        seed_load;
    logic [15:0] seed_in;

    modport master (
        output food_valid_1, food_valid_2, seed_load, seed_in,
        input  new_food_x1, new_food_y1, new_food_x2, new_food_y2,
        input  food_received_1, food_received_2, busy
    );
    modport slave (
        input  food_valid_1, food_valid_2, seed_load, seed_in,
        output new_food_x1, new_food_y1, new_food_x2, new_food_y2,
        output food_received_1, food_received_2, busy
    );
`else
    modport master (
        output food_valid_1, food_valid_2,
        input  new_food_x1, new_food_y1, new_food_x2, new_food_y2,
        input  food_received_1, food_received_2, busy
    );
    modport slave (
        input  food_valid_1, food_valid_2,
        output new_food_x1, new_food_y1, new_food_x2, new_food_y2,
        output food_received_1, food_received_2, busy
    );
`endif
endinterface

// File: rtl/food_spawn_arbiter.sv
// rtl/food_spawn_arbiter.sv - round-robin arbiter sharing one LFSR food-position generator between two channels
// Optional feature: FOOD_SEED_LOAD_EN adds a runtime LFSR seed load.
module food_spawn_arbiter #(
    parameter int           GRID_W    = 160,
    parameter int           GRID_H    = 120,
    parameter logic [15:0]  LFSR_SEED = 16'hACE1,
    parameter int           MAX_TRIES = 15,
    parameter logic [7:0]   INIT_X1   = 8'd40,
    parameter logic [6:0]   INIT_Y1   = 7'd60,
    parameter logic [7:0]   INIT_X2   = 8'd120,
    parameter logic [6:0]   INIT_Y2   = 7'd60
) (
    input  logic                 clk,
    input  logic                 resetn,
    food_spawn_arbiter_if.slave  fif
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_DRAW = 2'd1;
    localparam logic [1:0]  S_ACK  = 2'd2;
    localparam logic [1:0]  S_COOL = 2'd3;

    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  FB_X     = 8'(GRID_W / 2);
    localparam logic [7:0]  FB_X_ALT = 8'(GRID_W / 2 + 1);
    localparam logic [6:0]  FB_Y     = 7'(GRID_H / 2);
    localparam logic [7:0]  TRY_LAST = 8'(MAX_TRIES - 1);
    localparam logic [8:0]  GW_LIM   = 9'(GRID_W);
    localparam logic [7:0]  GH_LIM   = 8'(GRID_H);

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_step;
    logic [15:0] lfsr_next;
    logic [7:0]  tries;
    logic        grant;       // 0 = channel 1, 1 = channel 2
    logic        last_grant;
    logic [7:0]  x1, x2;
    logic [6:0]  y1, y2;
    logic        rx1, rx2;

    logic [7:0]  cx;
    logic [6:0]  cy;
    logic [7:0]  gx, ox, fb_x;
    logic [6:0]  gy, oy;
    logic        in_grid, hit_other, hit_self, accept;

    always_comb begin
        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
`ifdef FOOD_SEED_LOAD_EN
        if (fif.seed_load)
            lfsr_next = (fif.seed_in == 16'h0000) ? 16'h0001 : fif.seed_in;
        else
            lfsr_next = lfsr_step;
`else
        lfsr_next = lfsr_step;
`endif
    end

    always_comb begin
        cx        = lfsr[7:0];
        cy        = lfsr[14:8];
        gx        = grant ? x2 : x1;
        gy        = grant ? y2 : y1;
        ox        = grant ? x1 : x2;
        oy        = grant ? y1 : y2;
        in_grid   = ({1'b0, cx} < GW_LIM) && ({1'b0, cy} < GH_LIM);
        hit_other = (cx == ox) && (cy == oy);
        hit_self  = (cx == gx) && (cy == gy);
        accept    = in_grid && !hit_other && !hit_self;
        // Centre fallback shifts one column right if the other food already sits there
        fb_x      = ((FB_X == ox) && (FB_Y == oy)) ? FB_X_ALT : FB_X;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            lfsr       <= SEED_EFF;
            tries      <= 8'd0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            x1         <= INIT_X1;
            y1         <= INIT_Y1;
            x2         <= INIT_X2;
            y2         <= INIT_Y2;
            rx1        <= 1'b0;
            rx2        <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            rx1  <= 1'b0;
            rx2  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fif.food_valid_1 || fif.food_valid_2) begin
                        if (fif.food_valid_1 && fif.food_valid_2)
                            grant <= ~last_grant;
                        else
                            grant <= fif.food_valid_2;
                        tries <= 8'd0;
                        state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (accept || (tries == TRY_LAST)) begin
                        if (grant) begin
                            x2  <= accept ? cx : fb_x;
                            y2  <= accept ? cy : FB_Y;
                            rx2 <= 1'b1;
                        end else begin
                            x1  <= accept ? cx : fb_x;
                            y1  <= accept ? cy : FB_Y;
                            rx1 <= 1'b1;
                        end
                        state <= S_ACK;
                    end else begin
                        tries <= tries + 8'd1;
                    end
                end
                S_ACK: begin
                    last_grant <= grant;
                    state      <= S_COOL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fif.new_food_x1     = x1;
    assign fif.new_food_y1     = y1;
    assign fif.new_food_x2     = x2;
    assign fif.new_food_y2     = y2;
    assign fif.food_received_1 = rx1;
    assign fif.food_received_2 = rx2;
    assign fif.busy            = (state != S_IDLE);
endmodule
